// File: rtl/id_stage.sv
// Instruction-decode stage: main control decoder, ALU-control decoder,
// 32x32 register file with two async read ports, and immediate sign-extender.
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_out1,
    output logic [31:0] rd_out2,
    output logic [31:0] sign_extend,
    output logic        RegDest,
    output logic        Jump,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic [1:0]  ALUOp,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [3:0]  ALUInput
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [5:0]  funct;
    logic [4:0]  wr_addr;
    logic [31:0] regs [32];

    assign op    = instruction[31:26];
    assign rs    = instruction[25:21];
    assign rt    = instruction[20:16];
    assign rd    = instruction[15:11];
    assign imm   = instruction[15:0];
    assign funct = instruction[5:0];

    assign sign_extend = {{16{imm[15]}}, imm};

    // Main control decode; unknown opcodes leave every strobe low so nothing is written or accessed.
    always_comb begin
        {RegDest, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp} = 10'b0;
        unique case (op)
            OP_RTYPE: {RegDest, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp} = 10'b1001000010;
            OP_LW:    {RegDest, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp} = 10'b0111100000;
            OP_SW:    {RegDest, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp} = 10'b0100010000;
            OP_BEQ:   {RegDest, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp} = 10'b0000001001;
            OP_ADDI:  {RegDest, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp} = 10'b0101000000;
            OP_J:     {RegDest, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp} = 10'b0000000100;
            default:  {RegDest, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp} = 10'b0;
        endcase
    end

    // ALU function select from ALUOp, falling back to funct for R-type; 1111 marks an undefined op.
    always_comb begin
        ALUInput = 4'b1111;
        case (ALUOp)
            2'b00: ALUInput = 4'b0010;
            2'b01: ALUInput = 4'b0110;
            2'b10: begin
                case (funct)
                    FN_ADD:  ALUInput = 4'b0010;
                    FN_SUB:  ALUInput = 4'b0110;
                    FN_AND:  ALUInput = 4'b0000;
                    FN_OR:   ALUInput = 4'b0001;
                    FN_SLT:  ALUInput = 4'b0111;
                    FN_NOR:  ALUInput = 4'b1100;
                    default: ALUInput = 4'b1111;
                endcase
            end
            default: ALUInput = 4'b1111;
        endcase
    end

    assign wr_addr = RegDest ? rd : rt;

    // Register file update: reset wipes every entry and swallows any write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (RegWrite && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Register 0 is forced to read zero regardless of array contents.
    assign rd_out1 = (rs == 5'd0) ? 32'h0 : regs[rs];
    assign rd_out2 = (rt == 5'd0) ? 32'h0 : regs[rt];

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a driver issues instructions and pushes expected
// outputs computed from a register-array model; a monitor pops and compares.
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] wr_data;
    logic [31:0] rd_out1, rd_out2, sign_extend;
    logic        RegDest, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0]  ALUOp;
    logic [3:0]  ALUInput;

    id_stage dut (
        .clk(clk), .reset(reset), .instruction(instruction), .wr_data(wr_data),
        .rd_out1(rd_out1), .rd_out2(rd_out2), .sign_extend(sign_extend),
        .RegDest(RegDest), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
        .MemtoReg(MemtoReg), .ALUOp(ALUOp), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .ALUInput(ALUInput)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          chk_rd;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] se;
        logic [9:0]  ctl;
        logic [3:0]  alu;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[32];
    bit          model_known = 0;
    int          total = 0;
    int          bad = 0;
    int          txn = 0;

    // Control table keyed on opcode: {RegDest,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp}
    function automatic logic [9:0] ref_ctl(input logic [5:0] op);
        case (op)
            6'b000000: return 10'b1001000010;
            6'b100011: return 10'b0111100000;
            6'b101011: return 10'b0100010000;
            6'b000100: return 10'b0000001001;
            6'b001000: return 10'b0101000000;
            6'b000010: return 10'b0000000100;
            default:   return 10'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input logic [1:0] aluop, input logic [5:0] funct);
        if (aluop == 2'b00) return 4'b0010;
        if (aluop == 2'b01) return 4'b0110;
        if (aluop == 2'b11) return 4'b1111;
        case (funct)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'b0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] wd, input logic rst);
        exp_t        e;
        logic [9:0]  c;
        int          rs, rt, rd, waddr;
        @(posedge clk);
        #1;
        instruction = ins;
        wr_data     = wd;
        reset       = rst;
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        rd = int'(ins[15:11]);
        c  = ref_ctl(ins[31:26]);
        e.id     = txn;
        e.chk_rd = model_known;
        e.r1     = (rs == 0) ? 32'h0 : model[rs];
        e.r2     = (rt == 0) ? 32'h0 : model[rt];
        e.se     = 32'(signed'(ins[15:0]));
        e.ctl    = c;
        e.alu    = ref_alu(c[1:0], ins[5:0]);
        sb.push_back(e);
        txn++;
        // effect of the coming edge on architectural state
        if (rst) begin
            foreach (model[i]) model[i] = 32'h0;
            model_known = 1;
        end else if (c[6]) begin
            waddr = c[9] ? rd : rt;
            if (waddr != 0) model[waddr] = wd;
        end
    endtask

    task automatic cmp(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s txn=%0d got=%h want=%h", name, id, got, want);
        end
    endtask

    // Monitor: compare the DUT's combinational view mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_rd) begin
                    cmp("rd_out1", e.id, rd_out1, e.r1);
                    cmp("rd_out2", e.id, rd_out2, e.r2);
                end
                cmp("sign_extend", e.id, sign_extend, e.se);
                cmp("control", e.id,
                    32'({RegDest, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp}),
                    32'(e.ctl));
                cmp("ALUInput", e.id, 32'(ALUInput), 32'(e.alu));
            end
        end
    end

    logic [5:0] op_pool[7];
    logic [5:0] fn_pool[7];

    initial begin
        logic [5:0]  op, fn;
        logic [31:0] ins;
        reset       = 1'b1;
        instruction = 32'h0;
        wr_data     = 32'h0;
        op_pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000111};

        // reset cycle with a decodable instruction, then reads after reset
        issue(rtype(5, 31, 3, 6'b100000), 32'h1111_1111, 1'b1);
        issue(itype(6'b101011, 5, 31, 16'h0004), 32'h0, 1'b0);
        // R-type functs, first writes reg3
        issue(rtype(1, 2, 3, 6'b100000), 32'h1234_5678, 1'b0);
        issue(rtype(3, 0, 4, 6'b100010), 32'h0000_0044, 1'b0);
        issue(rtype(3, 4, 5, 6'b100100), 32'h0000_0055, 1'b0);
        issue(rtype(4, 5, 6, 6'b100101), 32'h0000_0066, 1'b0);
        issue(rtype(5, 6, 8, 6'b101010), 32'h0000_0088, 1'b0);
        issue(rtype(6, 8, 10, 6'b100111), 32'h0000_00AA, 1'b0);
        issue(rtype(3, 10, 11, 6'b000111), 32'h0000_00BB, 1'b0);
        // lw with negative and positive immediate
        issue(itype(6'b100011, 3, 7, 16'hFFFC), 32'hDEAD_BEEF, 1'b0);
        issue(itype(6'b100011, 7, 3, 16'h7FFF), 32'h0BAD_F00D, 1'b0);
        // sw / beq / j / unknown must not write
        issue(itype(6'b101011, 7, 3, 16'h0010), 32'hFFFF_0001, 1'b0);
        issue(itype(6'b000100, 7, 3, 16'h8000), 32'hFFFF_0002, 1'b0);
        issue({6'b000010, 26'h3FF_FFFF}, 32'hFFFF_0003, 1'b0);
        issue({6'b111111, 26'h00E_7000}, 32'hFFFF_0004, 1'b0);
        issue(rtype(7, 3, 0, 6'b100000), 32'h0, 1'b0);
        // write to r0 is dropped
        issue(rtype(1, 1, 0, 6'b100000), 32'hFFFF_FFFF, 1'b0);
        issue(rtype(0, 0, 1, 6'b100000), 32'h0000_0001, 1'b0);
        // read-during-write on reg9, then reset mid-program
        issue(itype(6'b001000, 0, 9, 16'h0001), 32'hA5A5_A5A5, 1'b0);
        issue(rtype(9, 9, 9, 6'b100000), 32'h0000_0001, 1'b0);
        issue(rtype(9, 9, 12, 6'b100000), 32'h0000_0012, 1'b0);
        issue(itype(6'b001000, 9, 9, 16'h0000), 32'h7777_7777, 1'b1);
        issue(rtype(9, 12, 13, 6'b100000), 32'h0, 1'b0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            op  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 6)];
            fn  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 6)];
            ins = $urandom;
            ins[31:26] = op;
            if (op == 6'b000000) ins[5:0] = fn;
            issue(ins, $urandom, ($urandom_range(0, 49) == 0));
        end

        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
